// File: rtl/ws_systolic_array_v2.sv
`default_nettype none
// ============================================================================
// Module      : ws_systolic_array_v2
// Description : Weight-stationary systolic array with input skew and output
//               deskew, a shadow/active weight bank with drain-safe swap,
//               runtime row/column masking and signed/unsigned operands.
// Revision    : 2.0 - initial parametrised release
// ============================================================================
module ws_systolic_array_v2 #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 2*DATA_WIDTH + $clog2(ROWS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_load,
    input  logic [$clog2(ROWS+1)-1:0]      cfg_rows,
    input  logic [$clog2(COLS+1)-1:0]      cfg_cols,
    input  logic                           cfg_signed,
    output logic                           cfg_err,
    input  logic                           w_v,
    input  logic [$clog2(ROWS)-1:0]        w_row,
    input  logic [COLS*DATA_WIDTH-1:0]     w_d,
    input  logic                           w_swap,
    output logic                           swap_done,
    input  logic                           in_v,
    output logic                           in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]     in_d,
    output logic                           out_v,
    output logic [COLS*PSUM_WIDTH-1:0]     out_d,
    output logic                           busy
);
    localparam int LAT = ROWS + COLS;
    localparam int RW  = $clog2(ROWS+1);
    localparam int CW  = $clog2(COLS+1);
    localparam int NW  = $clog2(LAT+1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_SWAP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]           cfg_rows_q;
    logic [CW-1:0]           cfg_cols_q;
    logic                    cfg_signed_q;
    logic                    cfg_err_q;
    logic [LAT-1:0]          vld_q;
    logic                    out_v_q;
    logic [COLS*PSUM_WIDTH-1:0] out_d_q;
    logic [DATA_WIDTH-1:0]   wsh_q  [ROWS][COLS];
    logic [DATA_WIDTH-1:0]   wact_q [ROWS][COLS];

    logic                    w_accept;
    logic                    w_retire;
    logic                    w_cfg_ok;
    logic [DATA_WIDTH-1:0]   w_xs [ROWS];
    logic [DATA_WIDTH-1:0]   w_a  [ROWS][COLS-1];
    logic [PSUM_WIDTH-1:0]   w_ps [ROWS][COLS];
    logic [PSUM_WIDTH-1:0]   w_yd [COLS];

    function automatic logic [PSUM_WIDTH-1:0] f_ext(input logic [DATA_WIDTH-1:0] v,
                                                    input logic sgn);
        f_ext = {{(PSUM_WIDTH-DATA_WIDTH){sgn & v[DATA_WIDTH-1]}}, v};
    endfunction

    assign in_ready  = (state_q == S_RUN);
    assign w_accept  = in_v && in_ready;
    // A vector leaves the in-flight count on the edge that raises its out_v.
    assign w_retire  = vld_q[LAT-1];
    assign w_cfg_ok  = (cnt_q == '0) && !w_accept &&
                       (cfg_rows != '0) && (cfg_rows <= RW'(ROWS)) &&
                       (cfg_cols != '0) && (cfg_cols <= CW'(COLS));
    assign swap_done = (state_q == S_SWAP);
    assign busy      = (cnt_q != '0) || (state_q != S_RUN);
    assign cfg_err   = cfg_err_q;
    assign out_v     = out_v_q;
    assign out_d     = out_d_q;

    // Next state: drain the pipe before copying shadow weights to active.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (w_swap) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == '0) state_d = S_SWAP;
            S_SWAP:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // In-flight count: accept adds one, retire removes one.
    always_comb begin
        cnt_d = cnt_q;
        if (w_accept && !w_retire)      cnt_d = cnt_q + NW'(1);
        else if (!w_accept && w_retire) cnt_d = cnt_q - NW'(1);
    end

    // Control state, counter and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            cnt_q        <= '0;
            cfg_rows_q   <= RW'(ROWS);
            cfg_cols_q   <= CW'(COLS);
            cfg_signed_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= 1'b0;
            if (cfg_load) begin
                if (w_cfg_ok) begin
                    cfg_rows_q   <= cfg_rows;
                    cfg_cols_q   <= cfg_cols;
                    cfg_signed_q <= cfg_signed;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    // Weight banks: copy reads pre-write shadow contents; a same-edge write lands after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    wsh_q[i][j]  <= '0;
                    wact_q[i][j] <= '0;
                end
            end
        end else begin
            if (state_q == S_SWAP) begin
                for (int i = 0; i < ROWS; i++) begin
                    for (int j = 0; j < COLS; j++) wact_q[i][j] <= wsh_q[i][j];
                end
            end
            if (w_v) begin
                for (int j = 0; j < COLS; j++) wsh_q[w_row][j] <= w_d[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Input skew: row i is captured (masked) then delayed i more cycles.
    for (genvar i = 0; i < ROWS; i++) begin : g_skew
        logic [DATA_WIDTH-1:0] sk_q [i+1];
        // Masked capture followed by an i-deep delay line.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) sk_q[k] <= '0;
            end else begin
                sk_q[0] <= (cfg_rows_q > RW'(i)) ? in_d[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= i; k++) sk_q[k] <= sk_q[k-1];
            end
        end
        assign w_xs[i] = sk_q[i];
    end

    // PE grid: operands move right, partial sums move down.
    for (genvar i = 0; i < ROWS; i++) begin : g_pe_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe_col
            logic [DATA_WIDTH-1:0] w_a_in;
            logic [PSUM_WIDTH-1:0] w_p_in;
            logic [PSUM_WIDTH-1:0] w_prod;
            logic [PSUM_WIDTH-1:0] ps_q;

            if (j == 0) begin : g_src_edge
                assign w_a_in = w_xs[i];
            end else begin : g_src_left
                assign w_a_in = w_a[i][j-1];
            end
            if (i == 0) begin : g_top
                assign w_p_in = '0;
            end else begin : g_acc
                assign w_p_in = w_ps[i-1][j];
            end

            assign w_prod = f_ext(w_a_in, cfg_signed_q) * f_ext(wact_q[i][j], cfg_signed_q);

            // Add this PE's product to the psum arriving from above.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) ps_q <= '0;
                else     ps_q <= w_p_in + w_prod;
            end
            assign w_ps[i][j] = ps_q;

            if (j < COLS-1) begin : g_fwd
                logic [DATA_WIDTH-1:0] a_q;
                // Forward the operand to the right-hand neighbour.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) a_q <= '0;
                    else     a_q <= w_a_in;
                end
                assign w_a[i][j] = a_q;
            end
        end
    end

    // Output deskew: column j waits COLS-1-j cycles so all columns align.
    for (genvar j = 0; j < COLS; j++) begin : g_deskew
        if (j == COLS-1) begin : g_none
            assign w_yd[j] = w_ps[ROWS-1][j];
        end else begin : g_dly
            logic [PSUM_WIDTH-1:0] dq_q [COLS-1-j];
            // Delay line equalising column arrival times.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < COLS-1-j; k++) dq_q[k] <= '0;
                end else begin
                    dq_q[0] <= w_ps[ROWS-1][j];
                    for (int k = 1; k < COLS-1-j; k++) dq_q[k] <= dq_q[k-1];
                end
            end
            assign w_yd[j] = dq_q[COLS-2-j];
        end
    end

    // Valid tracking and masked output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            out_v_q <= 1'b0;
            out_d_q <= '0;
        end else begin
            vld_q   <= {vld_q[LAT-2:0], w_accept};
            out_v_q <= vld_q[LAT-1];
            for (int j = 0; j < COLS; j++) begin
                out_d_q[j*PSUM_WIDTH +: PSUM_WIDTH] <= (cfg_cols_q > CW'(j)) ? w_yd[j] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ws_systolic_array_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws_systolic_array_v2
// Description : Directed self-checking bench for ws_systolic_array_v2.
// Revision    : 2.0 - initial release
// ============================================================================
module tb_ws_systolic_array_v2;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int PW   = 2*DW + $clog2(ROWS);
    localparam int LAT  = ROWS + COLS;
    localparam int RW   = $clog2(ROWS+1);
    localparam int CW   = $clog2(COLS+1);

    logic                  clk;
    logic                  rst;
    logic                  cfg_load;
    logic [RW-1:0]         cfg_rows;
    logic [CW-1:0]         cfg_cols;
    logic                  cfg_signed;
    logic                  cfg_err;
    logic                  w_v;
    logic [$clog2(ROWS)-1:0] w_row;
    logic [COLS*DW-1:0]    w_d;
    logic                  w_swap;
    logic                  swap_done;
    logic                  in_v;
    logic                  in_ready;
    logic [ROWS*DW-1:0]    in_d;
    logic                  out_v;
    logic [COLS*PW-1:0]    out_d;
    logic                  busy;

    ws_systolic_array_v2 #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_signed(cfg_signed), .cfg_err(cfg_err),
        .w_v(w_v), .w_row(w_row), .w_d(w_d), .w_swap(w_swap), .swap_done(swap_done),
        .in_v(in_v), .in_ready(in_ready), .in_d(in_d),
        .out_v(out_v), .out_d(out_d), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_y [COLS];
    logic [COLS*DW-1:0] wrow;
    logic [ROWS*DW-1:0] xv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] y_at(input int j);
        return 32'(out_d[j*PW +: PW]);
    endfunction

    function automatic logic [31:0] trunc(input int v);
        logic [PW-1:0] t;
        t = v[PW-1:0];
        return 32'(t);
    endfunction

    task automatic write_row(input int r, input logic [COLS*DW-1:0] d);
        w_v = 1'b1; w_row = r[$clog2(ROWS)-1:0]; w_d = d;
        tick();
        w_v = 1'b0;
    endtask

    task automatic do_swap(input string tag);
        bit seen;
        seen = 1'b0;
        w_swap = 1'b1;
        tick();
        w_swap = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            if (swap_done) seen = 1'b1;
        end
        check({tag, "_swap"}, 32'(seen), 32'd1);
        tick();
    endtask

    task automatic do_cfg(input string tag, input int r, input int c, input bit s);
        cfg_load = 1'b1; cfg_rows = r[RW-1:0]; cfg_cols = c[CW-1:0]; cfg_signed = s;
        tick();
        cfg_load = 1'b0;
        check({tag, "_cfg_ok"}, 32'(cfg_err), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Send n back-to-back copies of x, then check out_v timing and every result.
    task automatic stream(input string tag, input int n, input logic [ROWS*DW-1:0] x);
        int nout;
        nout = 0;
        in_d = x;
        for (int e = 1; e <= n + LAT + 2; e++) begin
            in_v = (e <= n);
            if (e <= n) check({tag, "_rdy"}, 32'(in_ready), 32'd1);
            tick();
            in_v = 1'b0;
            check($sformatf("%s_outv_e%0d", tag, e), 32'(out_v),
                  32'((e >= LAT + 1) && (e <= LAT + n)));
            if (out_v) begin
                nout++;
                for (int j = 0; j < COLS; j++)
                    check($sformatf("%s_y%0d", tag, j), y_at(j), trunc(exp_y[j]));
            end
        end
        check({tag, "_count"}, 32'(nout), 32'(n));
    endtask

    initial begin
        int  nout;
        bit  seen;
        bit  any_v;

        rst = 1'b1; cfg_load = 1'b0; cfg_rows = '0; cfg_cols = '0; cfg_signed = 1'b0;
        w_v = 1'b0; w_row = '0; w_d = '0; w_swap = 1'b0; in_v = 1'b0; in_d = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_outv",   32'(out_v),     32'd0);
        check("rst_outd",   32'(|out_d),    32'd0);
        check("rst_cfgerr", 32'(cfg_err),   32'd0);
        check("rst_swapd",  32'(swap_done), 32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_rdy",    32'(in_ready),  32'd1);

        // T1: identity weights, exact swap timing, x=[1..8]
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) wrow[j*DW +: DW] = (i == j) ? 8'd1 : 8'd0;
            write_row(i, wrow);
        end
        w_swap = 1'b1;
        tick();
        w_swap = 1'b0;
        check("t1_drain_rdy",  32'(in_ready),  32'd0);
        check("t1_drain_busy", 32'(busy),      32'd1);
        check("t1_sd_early",   32'(swap_done), 32'd0);
        tick();
        check("t1_swap_done",  32'(swap_done), 32'd1);
        tick();
        check("t1_sd_pulse",   32'(swap_done), 32'd0);
        check("t1_run_rdy",    32'(in_ready),  32'd1);
        for (int i = 0; i < ROWS; i++) xv[i*DW +: DW] = DW'(i + 1);
        for (int j = 0; j < COLS; j++) exp_y[j] = j + 1;
        stream("t1", 1, xv);

        // T2: signed, W[i][j]=i-j, x=-1 -> y[j]=sum_i (j-i) = 8j-28
        do_cfg("t2", 8, 8, 1'b1);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) wrow[j*DW +: DW] = DW'(i - j);
            write_row(i, wrow);
        end
        do_swap("t2");
        xv = '1;
        for (int j = 0; j < COLS; j++) exp_y[j] = 8*j - 28;
        stream("t2", 10, xv);

        // T3: 3x3 masking with all-ones operands
        do_cfg("t3", 3, 3, 1'b0);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) wrow[j*DW +: DW] = 8'd1;
            write_row(i, wrow);
        end
        do_swap("t3");
        for (int i = 0; i < ROWS; i++) xv[i*DW +: DW] = 8'd1;
        for (int j = 0; j < COLS; j++) exp_y[j] = (j < 3) ? 3 : 0;
        stream("t3", 1, xv);
        // cfg_load while a vector is in flight is rejected
        in_d = xv; in_v = 1'b1;
        tick();
        in_v = 1'b0;
        cfg_load = 1'b1; cfg_rows = RW'(8); cfg_cols = CW'(8); cfg_signed = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("t3_cfgerr_pulse", 32'(cfg_err), 32'd1);
        check("t3_busy",         32'(busy),    32'd1);
        tick();
        check("t3_cfgerr_end",   32'(cfg_err), 32'd0);
        wait_idle("t3");
        stream("t3b", 1, xv);
        do_cfg("t3c", 8, 8, 1'b0);

        // T4: swap requested right after 5 vectors under A drains them first
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) wrow[j*DW +: DW] = (i == j) ? 8'd1 : 8'd0;
            write_row(i, wrow);
        end
        do_swap("t4a");
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) wrow[j*DW +: DW] = (i == j) ? 8'd2 : 8'd0;
            write_row(i, wrow);
        end
        for (int i = 0; i < ROWS; i++) xv[i*DW +: DW] = DW'(i + 1);
        in_d = xv;
        for (int e = 1; e <= 5; e++) begin
            in_v = 1'b1;
            tick();
        end
        in_v = 1'b0;
        w_swap = 1'b1;
        tick();
        w_swap = 1'b0;
        nout = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            check("t4_rdy_low", 32'(in_ready), 32'd0);
            tick();
            if (out_v) begin
                nout++;
                for (int j = 0; j < COLS; j++)
                    check($sformatf("t4_a_y%0d", j), y_at(j), 32'(j + 1));
            end
            if (swap_done) begin
                seen = 1'b1;
                check("t4_outs_before_swap", 32'(nout), 32'd5);
            end
        end
        check("t4_swap_seen", 32'(seen), 32'd1);
        tick();
        for (int j = 0; j < COLS; j++) exp_y[j] = 2*(j + 1);
        stream("t4b", 1, xv);

        // T5: 0xFF operands, unsigned then signed
        do_cfg("t5u", 8, 8, 1'b0);
        for (int i = 0; i < ROWS; i++) write_row(i, '1);
        do_swap("t5");
        xv = '1;
        for (int j = 0; j < COLS; j++) exp_y[j] = 520200;
        stream("t5u", 1, xv);
        do_cfg("t5s", 8, 8, 1'b1);
        for (int j = 0; j < COLS; j++) exp_y[j] = 8;
        stream("t5s", 1, xv);

        // T6: reset with 4 vectors in flight
        in_d = '1;
        for (int e = 1; e <= 4; e++) begin
            in_v = 1'b1;
            tick();
        end
        in_v = 1'b0;
        check("t6_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_outv", 32'(out_v),    32'd0);
        check("t6_outd", 32'(|out_d),   32'd0);
        check("t6_rdy",  32'(in_ready), 32'd1);
        check("t6_busy", 32'(busy),     32'd0);
        tick(); tick();
        rst = 1'b0;
        any_v = 1'b0;
        for (int k = 0; k < LAT + 8; k++) begin
            tick();
            any_v = any_v | out_v;
        end
        check("t6_no_outv", 32'(any_v), 32'd0);
        for (int i = 0; i < ROWS; i++) xv[i*DW +: DW] = 8'd1;
        for (int j = 0; j < COLS; j++) exp_y[j] = 0;
        stream("t6_w0", 1, xv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
